ws2812_tx_ctrl: RTL and testbench
=================================

Name: ws2812_tx_ctrl

Overview:
- Downstream stage of the 120-bit LED shift register; drives the single-wire WS2812 data line.
- Owns the register's `LoadRegister` and `RotateRegisterLeft` controls and consumes its `CurrentBit` output.
- Converts each bit into a timed high/low pulse and repeats the 120-bit word across the strip.
- Inserts the reset/latch low period between frames.

Parameters:
- NUM_BITS, 120: bits per register word; must match the shift-register width.
- WORD_REPEAT, 1: number of times the word is sent per frame (strip length / 5 modules).
- BIT_CYC, 125: clk cycles per bit period (1.25 us at 100 MHz).
- T0H_CYC, 35: high cycles for a 0 bit.
- T1H_CYC, 70: high cycles for a 1 bit.
- RESET_CYC, 5000: low cycles of the inter-frame latch (50 us).
- Legal range: 2 <= T0H_CYC < T1H_CYC < BIT_CYC.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- Run  input  1  level; high = keep transmitting frames.
- CurrentBit  input  1  MSB of the shift register.
- LoadRegister  output  1  one-cycle pulse; shift register loads sw.
- RotateRegisterLeft  output  1  one-cycle pulse; advance to next bit.
- Data  output  1  serial line to the first LED module.
- Busy  output  1  high from LOAD through the last bit of a frame.
- FrameDone  output  1  one-cycle pulse at the end of a post-frame latch.

Behaviour:
- Interface: one clock, `clk`. `reset` is synchronous and active-high.
- While `reset` is sampled high:
  - All outputs are 0 on the following cycle.
  - State is LATCH, cycle counter = 0, bit and word counters = 0, internal SentFlag = 0.
- Counter widths:
  - Cycle counter covers max(BIT_CYC, RESET_CYC) - 1.
  - Bit counter covers NUM_BITS - 1.
  - Word counter covers WORD_REPEAT - 1.
  - Counters never wrap silently.
- State LATCH:
  - `Data` = 0 and `Busy` = 0.
  - Count RESET_CYC cycles (0..RESET_CYC-1), then saturate.
  - On the last count cycle, `FrameDone` = SentFlag, then SentFlag is cleared.
  - After the count completes: if `Run` = 1, go to LOAD; otherwise hold in LATCH (idle) until `Run` = 1, then go to LOAD the next cycle.
- State LOAD (1 cycle):
  - `LoadRegister` = 1 and `Busy` = 1; `Data` = 0.
  - Clear the bit and word counters, then go to BIT.
  - The shift register updates at this edge, so `CurrentBit` is valid from the first BIT cycle.
- State BIT:
  - Cycle counter c runs 0..BIT_CYC-1.
  - At c = 0: latch `CurrentBit` into BitVal, and drive `Data` = 1 regardless.
  - For c >= 1: `Data` = 1 while c < (BitVal ? T1H_CYC : T0H_CYC), else 0.
  - At c = BIT_CYC-1: `RotateRegisterLeft` = 1, including the final bit of the frame (the register returns to its loaded state after NUM_BITS rotates).
  - Bit advance: bit counter increments.
  - At NUM_BITS-1 the bit counter clears and the word counter increments.
  - At the last bit of the last word: set SentFlag, clear the cycle counter, go to LATCH.
- Data timing: `Data` is registered, so the waveform is 1 cycle delayed from the state, uniformly. Bit periods are back-to-back with no gap cycles.
- Pulse widths: `LoadRegister` and `RotateRegisterLeft` are never high together. Each is exactly one cycle wide.
- `Run` deasserted mid-frame:
  - The frame completes in full; no truncation.
  - Latch and `FrameDone` pulse as normal, then idle.
- `Run` during LATCH does not shorten the latch.
- `reset` mid-frame:
  - `Data` = 0 next cycle; the frame is abandoned.
  - A full RESET_CYC latch precedes any new LOAD, with no `FrameDone` for the abandoned frame.
- First latch after reset has SentFlag = 0, so no `FrameDone` pulse.
- Frame length = 1 + NUM_BITS*WORD_REPEAT*BIT_CYC cycles. Frame period with `Run` held = that value + RESET_CYC.

Test Plan:
- Reset then `Run` = 1 held:
  - All outputs 0 during reset.
  - `Data` low for 5000 cycles, then a single `LoadRegister` pulse.
  - No `FrameDone` at the end of that first latch.
- sw = 1 followed by 119 zeros:
  - First bit: `Data` high 70 cycles, low 55.
  - Each of the remaining 119 bits: high 35 cycles, low 90.
  - `Busy` high for 15001 cycles.
- WORD_REPEAT = 2:
  - Exactly 240 `RotateRegisterLeft` pulses, each on cycle 124 of its bit.
  - One `LoadRegister` pulse; the second word's waveform is identical to the first.
- `Run` held, defaults:
  - `FrameDone` pulses every 20001 cycles.
  - `LoadRegister` follows each `FrameDone` by 1 cycle.
- `Run` dropped at bit 50:
  - Remaining 70 bits are sent, then 5000-cycle latch and one `FrameDone`.
  - Block then idles with `Data` = 0 and no `LoadRegister` for 10000 cycles.
  - Raising `Run` gives `LoadRegister` 1 cycle later.
- `reset` pulsed at bit 60:
  - `Data` = 0 and `Busy` = 0 next cycle.
  - Next `LoadRegister` exactly 5000 cycles after reset release.
  - No `FrameDone` pulse.

Source files
------------

// File: rtl/ws2812_tx_ctrl.sv
// rtl/ws2812_tx_ctrl.sv - WS2812 single-wire transmitter driving a 120-bit LED shift register
//
// Walks the shift register bit by bit, turns each bit into a timed high/low
// pulse on Data, repeats the word WORD_REPEAT times per frame and separates
// frames with a RESET_CYC low latch period.
//
// Ports:
//   clk                - system clock, all logic on posedge
//   reset              - synchronous, active-high
//   Run                - level; high keeps frames going back to back
//   CurrentBit         - MSB of the shift register
//   LoadRegister       - one-cycle pulse, shift register loads its word
//   RotateRegisterLeft - one-cycle pulse, shift register advances one bit
//   Data               - registered serial line to the first LED module
//   Busy               - high from LOAD through the last bit of a frame
//   FrameDone          - one-cycle pulse at the end of a post-frame latch

module ws2812_tx_ctrl #(
    parameter int NUM_BITS    = 120,
    parameter int WORD_REPEAT = 1,
    parameter int BIT_CYC     = 125,
    parameter int T0H_CYC     = 35,
    parameter int T1H_CYC     = 70,
    parameter int RESET_CYC   = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic Run,
    input  logic CurrentBit,
    output logic LoadRegister,
    output logic RotateRegisterLeft,
    output logic Data,
    output logic Busy,
    output logic FrameDone
);

    localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BW      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int WW      = (WORD_REPEAT > 1) ? $clog2(WORD_REPEAT) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);
    localparam logic [BW-1:0] NB_LAST  = BW'(NUM_BITS - 1);
    localparam logic [WW-1:0] WR_LAST  = WW'(WORD_REPEAT - 1);

    typedef enum logic [1:0] {
        S_LATCH = 2'd0,
        S_LOAD  = 2'd1,
        S_BIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [WW-1:0] word_q, word_d;
    logic          sent_q, sent_d;
    logic          bitval_q, bitval_d;
    logic          data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LATCH;
            cyc_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            sent_q   <= 1'b0;
            bitval_q <= 1'b0;
            data_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            sent_q   <= sent_d;
            bitval_q <= bitval_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cyc_d              = cyc_q;
        bit_d              = bit_q;
        word_d             = word_q;
        sent_d             = sent_q;
        bitval_d           = bitval_q;
        data_d             = 1'b0;
        LoadRegister       = 1'b0;
        RotateRegisterLeft = 1'b0;
        Busy               = 1'b0;
        FrameDone          = 1'b0;

        case (state_q)
            S_LATCH: begin
                // The counter parks on its last value while idle; SentFlag is
                // already clear then, so FrameDone cannot repeat.
                if (cyc_q == RST_LAST) begin
                    FrameDone = sent_q;
                    sent_d    = 1'b0;
                    if (Run) begin
                        state_d = S_LOAD;
                        cyc_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            S_LOAD: begin
                LoadRegister = 1'b1;
                Busy         = 1'b1;
                bit_d        = '0;
                word_d       = '0;
                cyc_d        = '0;
                state_d      = S_BIT;
            end

            S_BIT: begin
                Busy = 1'b1;
                // BitVal is only valid from cycle 1, so cycle 0 is forced high.
                if (cyc_q == '0) begin
                    bitval_d = CurrentBit;
                    data_d   = 1'b1;
                end else begin
                    data_d = (cyc_q < (bitval_q ? T1H : T0H));
                end

                if (cyc_q == BIT_LAST) begin
                    // Rotate on every bit, the last one included, so the
                    // register wraps back to its loaded word for the next repeat.
                    RotateRegisterLeft = 1'b1;
                    cyc_d              = '0;
                    if (bit_q == NB_LAST) begin
                        bit_d = '0;
                        if (word_q == WR_LAST) begin
                            word_d  = '0;
                            sent_d  = 1'b1;
                            state_d = S_LATCH;
                        end else begin
                            word_d = word_q + WW'(1);
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            default: begin
                state_d = S_LATCH;
                cyc_d   = '0;
            end
        endcase
    end

    assign Data = data_q;

endmodule

// File: tb/tb_ws2812_tx_ctrl.sv
// tb/tb_ws2812_tx_ctrl.sv - directed self-checking bench for ws2812_tx_ctrl

module tb_ws2812_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, run_a, run_b;
    logic         cb_a, load_a, rot_a, data_a, busy_a, fd_a;
    logic         cb_b, load_b, rot_b, data_b, busy_b, fd_b;
    logic [119:0] sw_a, sw_b, sr_a, sr_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ws2812_tx_ctrl u_a (
        .clk(clk), .reset(reset), .Run(run_a), .CurrentBit(cb_a),
        .LoadRegister(load_a), .RotateRegisterLeft(rot_a),
        .Data(data_a), .Busy(busy_a), .FrameDone(fd_a)
    );

    ws2812_tx_ctrl #(.WORD_REPEAT(2)) u_b (
        .clk(clk), .reset(reset), .Run(run_b), .CurrentBit(cb_b),
        .LoadRegister(load_b), .RotateRegisterLeft(rot_b),
        .Data(data_b), .Busy(busy_b), .FrameDone(fd_b)
    );

    // Shift-register models feeding CurrentBit
    always @(posedge clk) begin
        if (load_a)     sr_a <= sw_a;
        else if (rot_a) sr_a <= {sr_a[118:0], sr_a[119]};
        if (load_b)     sr_b <= sw_b;
        else if (rot_b) sr_b <= {sr_b[118:0], sr_b[119]};
    end
    assign cb_a = sr_a[119];
    assign cb_b = sr_b[119];

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected Data for the 1-then-119-zeros word, t ticks after the LOAD tick
    function automatic logic exp_a(input int t);
        int c, b;
        if (t < 2) return 1'b0;
        c = (t - 2) % 125;
        b = (t - 2) / 125;
        if (b > 119) return 1'b0;
        return (c < ((b == 0) ? 70 : 35));
    endfunction

    // Monitor for the WORD_REPEAT=2 instance, over its first frame
    int   b_t = -1;
    int   b_loads = 0, b_rots = 0, b_rot_bad = 0;
    int   b_hi [240];
    logic b_done = 1'b0;

    initial begin
        for (int i = 0; i < 240; i++) b_hi[i] = 0;
        while (!b_done) begin
            @(negedge clk);
            if (reset !== 1'b0) continue;
            if (b_t < 0) begin
                if (load_b) begin
                    b_t     = 0;
                    b_loads = 1;
                end
            end else begin
                b_t++;
                if (load_b) b_loads++;
                if (rot_b) begin
                    b_rots++;
                    if (((b_t - 1) % 125) != 124) b_rot_bad++;
                end
                if (b_t >= 2 && data_b) b_hi[(b_t - 2) / 125]++;
                if (b_t == 30001) b_done = 1'b1;
            end
        end
    end

    initial begin
        int   n, t, busy_cnt, data_bad, rots, rot_bad, loads, bad, rots2, fd1;
        int   hi [120];
        logic fd_seen, data_seen, acc;

        sw_a  = {1'b1, 119'b0};
        sw_b  = 120'hF0F0_0123_4567_89AB_CDEF_5A5A_C3C3_A5;
        reset = 1'b1;
        run_a = 1'b0;
        run_b = 1'b0;

        // Reset: all outputs low
        repeat (3) begin
            tick;
            chk("reset_outs", int'({load_a, rot_a, data_a, busy_a, fd_a}), 0);
        end

        // First latch after reset: 5000 cycles, no FrameDone
        reset = 1'b0;
        run_a = 1'b1;
        run_b = 1'b1;
        n = 0; fd_seen = 1'b0; data_seen = 1'b0;
        while (!load_a && n < 6000) begin
            tick;
            n++;
            fd_seen   = fd_seen | fd_a;
            data_seen = data_seen | data_a;
        end
        chk("first_latch_len", n, 5000);
        chk("first_latch_no_fd", int'(fd_seen), 0);
        chk("first_latch_data_low", int'(data_seen), 0);
        chk("load_tick_rot", int'(rot_a), 0);

        // Frame 1: word = 1 followed by 119 zeros
        for (int i = 0; i < 120; i++) hi[i] = 0;
        busy_cnt = busy_a ? 1 : 0;
        data_bad = (data_a !== 1'b0) ? 1 : 0;
        rots = 0; rot_bad = 0; loads = 0;
        for (int k = 1; k <= 15001; k++) begin
            tick;
            if (busy_a) busy_cnt++;
            if (data_a !== exp_a(k)) data_bad++;
            if (k >= 2 && data_a) hi[(k - 2) / 125]++;
            if (rot_a) begin
                rots++;
                if (((k - 1) % 125) != 124) rot_bad++;
            end
            if (load_a) loads++;
        end
        chk("busy_len", busy_cnt, 15001);
        chk("data_shape", data_bad, 0);
        chk("bit0_high", hi[0], 70);
        chk("bit0_low", 125 - hi[0], 55);
        bad = 0;
        for (int i = 1; i < 120; i++) if (hi[i] != 35) bad++;
        chk("zero_bits_high35", bad, 0);
        chk("frame_rots", rots, 120);
        chk("rot_position", rot_bad, 0);
        chk("load_single_pulse", loads, 0);

        // Latch after frame 1 ends with FrameDone, then LOAD next cycle
        n = 0;
        while (!fd_a && n < 6000) begin
            tick;
            n++;
        end
        chk("latch_to_fd", n, 4999);
        fd1 = cyc;
        tick;
        chk("fd_width", int'(fd_a), 0);
        chk("load_after_fd", int'(load_a), 1);

        // Frame 2: Run dropped during bit 50; frame must complete
        t = 0; rots2 = 0;
        while (!fd_a && t < 25000) begin
            tick;
            t++;
            if (t == 6271) run_a = 1'b0;
            if (rot_a) rots2++;
        end
        chk("fd_period", cyc - fd1, 20001);
        chk("rots_after_run_drop", rots2, 120);

        // Idle: nothing moves for 10000 cycles
        acc = 1'b0;
        repeat (10000) begin
            tick;
            acc = acc | load_a | data_a | busy_a | fd_a | rot_a;
        end
        chk("idle_quiet", int'(acc), 0);

        run_a = 1'b1;
        tick;
        chk("run_to_load", int'(load_a), 1);

        // Frame 3: reset pulsed during bit 60
        repeat (7510) tick;
        chk("busy_mid_frame", int'(busy_a), 1);
        reset = 1'b1;
        tick;
        chk("reset_mid_outs", int'({data_a, busy_a, load_a, rot_a, fd_a}), 0);
        reset = 1'b0;
        n = 0; fd_seen = 1'b0;
        while (!load_a && n < 6000) begin
            tick;
            n++;
            fd_seen = fd_seen | fd_a;
        end
        chk("reset_to_load", n, 5000);
        chk("abandoned_no_fd", int'(fd_seen), 0);

        // WORD_REPEAT = 2 instance
        chk("b_frame_seen", int'(b_done), 1);
        chk("b_loads", b_loads, 1);
        chk("b_rots", b_rots, 240);
        chk("b_rot_position", b_rot_bad, 0);
        bad = 0;
        for (int i = 0; i < 240; i++)
            if (b_hi[i] != (sw_b[119 - (i % 120)] ? 70 : 35)) bad++;
        chk("b_waveform", bad, 0);
        bad = 0;
        for (int i = 0; i < 120; i++) if (b_hi[i] != b_hi[i + 120]) bad++;
        chk("b_words_identical", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
